// File: rtl/athena_hiscore_restore_pkg.sv
// rtl/athena_hiscore_restore_pkg.sv - shared types and constants for hiscore restore
//
// Purpose: side RAM request type, hiscore table geometry and restore FSM states.
//          HISCORE_SIZE is also the slot size reported to the host by the monitor.
package athena_hiscore_restore_pkg;

  localparam logic [10:0] HISCORE_BASE  = 11'h650;
  localparam int          HISCORE_SIZE  = 114;
  localparam int          HISCORE_IDX_W = 7;

  typedef logic [HISCORE_IDX_W-1:0] hiscore_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } hiscore_state_t;

  // One side RAM request as issued by the game core.
  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data_in;
    logic        nCS;
    logic        nWE;
    logic        nOE;
  } side_ram_t;

endpackage

// File: rtl/athena_hiscore_buffer.sv
// rtl/athena_hiscore_buffer.sv - simple dual-port image buffer for hiscore restore
//
// Purpose: holds the saved hiscore image; written from the dataslot load path,
//          read synchronously (one-cycle latency) by the injection path.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every clock
//   rd_data  - registered read data for the address presented one cycle earlier
module athena_hiscore_buffer #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  // No reset on the array or read register so the tools can map it to block RAM.
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/athena_hiscore_restore.sv
// rtl/athena_hiscore_restore.sv - injects a saved hiscore image into side RAM
//
// Purpose: buffers the hiscore image from the dataslot and, once the game has
//          written its default table, writes it to side RAM using only the
//          cycles in which the game leaves side RAM idle.
// Ports:
//   game_clk         - sole clock
//   reset_n          - synchronous active-low reset
//   load_valid       - one image byte presented this cycle
//   load_addr        - byte offset within the image
//   load_data        - image byte
//   load_done        - pulse: full image delivered
//   base_written     - game has written its default hiscore table
//   side_ram_monitor - game's side RAM request
//   side_ram_in      - request forwarded to side RAM
//   restore_busy     - injection in progress
//   restore_done     - sticky: whole image written
module athena_hiscore_restore
  import athena_hiscore_restore_pkg::*;
#(
  parameter logic [10:0] BASE_ADDR = HISCORE_BASE,
  parameter int          NUM_BYTES = HISCORE_SIZE,
  parameter int          IDX_W     = HISCORE_IDX_W
) (
  input  logic             game_clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [7:0]       load_data,
  input  logic             load_done,
  input  logic             base_written,
  input  side_ram_t        side_ram_monitor,
  output side_ram_t        side_ram_in,
  output logic             restore_busy,
  output logic             restore_done
);

  hiscore_state_t   state;
  logic [IDX_W-1:0] idx;
  logic             data_ready;
  logic             staged_valid;
  logic [7:0]       staged_data;
  logic [IDX_W-1:0] rd_addr;
  logic             buf_we;
  logic             inject;
  logic             last_byte;

  assign buf_we    = (state == IDLE) && load_valid && (int'(load_addr) < NUM_BYTES);
  assign last_byte = (idx == IDX_W'(NUM_BYTES - 1));

  // Gated by reset_n so a reset asserted mid-restore stops injection in that very cycle.
  assign inject = reset_n && (state == WRITE) && staged_valid && side_ram_monitor.nCS;

  // Present the next index while injecting so the following byte is staged
  // by the next cycle; otherwise re-read idx so the staged byte is held.
  assign rd_addr = inject ? idx + IDX_W'(1) : idx;

  // The buffer's registered read port doubles as the staging register.
  athena_hiscore_buffer #(
    .ADDR_W (IDX_W)
  ) u_buffer (
    .clk     (game_clk),
    .wr_en   (buf_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (staged_data)
  );

  always_comb begin
    side_ram_in = side_ram_monitor;
    if (inject) begin
      side_ram_in.addr    = BASE_ADDR + 11'(idx);
      side_ram_in.data_in = staged_data;
      side_ram_in.nCS     = 1'b0;
      side_ram_in.nWE     = 1'b0;
    end
  end

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      data_ready   <= 1'b0;
      staged_valid <= 1'b0;
      restore_busy <= 1'b0;
      restore_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx          <= '0;
          staged_valid <= 1'b0;
          if (load_done) begin
            data_ready <= 1'b1;
          end
          if (data_ready && base_written) begin
            state        <= WRITE;
            restore_busy <= 1'b1;
          end
        end
        WRITE: begin
          // First WRITE cycle is the prefetch of byte 0; staged from then on.
          staged_valid <= 1'b1;
          if (inject) begin
            idx <= idx + IDX_W'(1);
            if (last_byte) begin
              state        <= DONE;
              staged_valid <= 1'b0;
              restore_busy <= 1'b0;
              restore_done <= 1'b1;
            end
          end
        end
        DONE: begin
          restore_busy <= 1'b0;
          restore_done <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          restore_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_athena_hiscore_restore.sv
// tb/tb_athena_hiscore_restore.sv - self-checking bench for athena_hiscore_restore
module tb_athena_hiscore_restore;
  import athena_hiscore_restore_pkg::*;

  localparam int N = HISCORE_SIZE;

  logic       game_clk = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic [6:0] load_addr;
  logic [7:0] load_data;
  logic       load_done;
  logic       base_written;
  side_ram_t  side_ram_monitor;
  side_ram_t  side_ram_in;
  logic       restore_busy;
  logic       restore_done;

  athena_hiscore_restore dut (
    .game_clk         (game_clk),
    .reset_n          (reset_n),
    .load_valid       (load_valid),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .load_done        (load_done),
    .base_written     (base_written),
    .side_ram_monitor (side_ram_monitor),
    .side_ram_in      (side_ram_in),
    .restore_busy     (restore_busy),
    .restore_done     (restore_done)
  );

  always #5 game_clk = ~game_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] img [N];
  bit         armed = 1'b0;     // image delivered and base_written seen: writes allowed
  bit         mon_en = 1'b0;
  bit         traffic_on = 1'b0;
  int         inj_count = 0;    // bytes the model has seen written so far
  int         first_cyc = -1;
  int         last_cyc = -1;
  int         cyc = 0;
  bit         rst_at_edge = 1'b0;
  side_ram_t  exp_req;

  always @(posedge game_clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !reset_n;
  end

  // Per-cycle observer: every game request must pass through untouched; any other
  // difference must be the next image byte at the next table address.
  always @(negedge game_clk) begin
    if (mon_en) begin
      if (!reset_n) begin
        inj_count = 0;
        first_cyc = -1;
        check("reset_passthrough", 32'(side_ram_in), 32'(side_ram_monitor));
        if (rst_at_edge) begin
          check("reset_busy", 32'(restore_busy), 32'd0);
          check("reset_done", 32'(restore_done), 32'd0);
        end
      end else begin
        check("done_level", 32'(restore_done), 32'(inj_count == N));
        if (!armed) check("idle_busy", 32'(restore_busy), 32'd0);
        if (side_ram_monitor.nCS == 1'b0) begin
          check("game_wins", 32'(side_ram_in), 32'(side_ram_monitor));
        end else if (side_ram_in != side_ram_monitor) begin
          check("inject_allowed", 32'(armed), 32'd1);
          check("inject_in_range", 32'(inj_count < N), 32'd1);
          check("inject_busy", 32'(restore_busy), 32'd1);
          if (inj_count < N) begin
            exp_req         = side_ram_monitor;
            exp_req.addr    = HISCORE_BASE + 11'(inj_count);
            exp_req.data_in = img[inj_count];
            exp_req.nCS     = 1'b0;
            exp_req.nWE     = 1'b0;
            check("inject_req", 32'(side_ram_in), 32'(exp_req));
          end
          if (inj_count == 0) first_cyc = cyc;
          last_cyc = cyc;
          inj_count++;
        end
      end
    end
  end

  function automatic side_ram_t rand_req();
    side_ram_t r;
    r.addr    = 11'($urandom);
    r.data_in = 8'($urandom);
    r.nCS     = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
    r.nWE     = 1'($urandom);
    r.nOE     = 1'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge game_clk);
    #1;
    if (traffic_on) side_ram_monitor = rand_req();
  endtask

  task automatic game_idle();
    traffic_on = 1'b0;
    side_ram_monitor = '{addr: 11'h0, data_in: 8'h0, nCS: 1'b1, nWE: 1'b1, nOE: 1'b1};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    armed   = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic load_image();
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_addr  = 7'(i);
      load_data  = img[i];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic pulse_load_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic random_image();
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && !restore_done; k++) tick();
    check("wait_done", 32'(restore_done), 32'd1);
  endtask

  task automatic wait_count(input int target, input int limit);
    for (int k = 0; k < limit && inj_count < target; k++) tick();
    check("wait_count", 32'(inj_count >= target), 32'd1);
  endtask

  int t0;

  initial begin
    reset_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    load_done = 1'b0; base_written = 1'b0;
    game_idle();
    tick(); tick();
    mon_en = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Normal restore: image first, then base_written; game idle throughout.
    for (int i = 0; i < N; i++) img[i] = 8'(i) ^ 8'h5A;
    load_image();
    pulse_load_done();
    tick(); tick(); tick();
    t0 = cyc;
    base_written = 1'b1;
    armed = 1'b1;
    wait_done(400);
    check("normal_prefetch", 32'(first_cyc - t0), 32'd2);
    check("normal_back_to_back", 32'(last_cyc - first_cyc), 32'(N - 1));
    check("normal_count", 32'(inj_count), 32'(N));
    // Late load in DONE must not cause any further write.
    load_valid = 1'b1; load_addr = 7'd0; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("done_no_more", 32'(inj_count), 32'(N));

    // Contention, out-of-range load, late load in WRITE, base_written drop.
    do_reset();
    base_written = 1'b0;
    random_image();
    load_image();
    load_valid = 1'b1; load_addr = 7'h72; load_data = 8'hEE;
    tick();
    load_valid = 1'b0;
    pulse_load_done();
    base_written = 1'b1;
    armed = 1'b1;
    wait_count(20, 200);
    load_valid = 1'b1; load_addr = 7'(N - 1); load_data = ~img[N - 1];
    side_ram_monitor = '{addr: 11'h123, data_in: 8'($urandom), nCS: 1'b0, nWE: 1'b0, nOE: 1'b1};
    tick();
    load_valid = 1'b0;
    tick(); tick();
    game_idle();
    base_written = 1'b0;
    wait_done(400);
    check("contention_span", 32'(last_cyc - first_cyc), 32'(N - 1 + 3));
    check("contention_count", 32'(inj_count), 32'(N));

    // Order independence with random game traffic.
    do_reset();
    base_written = 1'b1;
    traffic_on = 1'b1;
    random_image();
    for (int k = 0; k < 50; k++) tick();
    load_image();
    t0 = cyc;
    armed = 1'b1;
    pulse_load_done();
    wait_done(3000);
    check("order_count", 32'(inj_count), 32'(N));
    check("order_latency", 32'(first_cyc - t0 >= 3), 32'd1);

    // No image: base_written high, random traffic, nothing may be written.
    do_reset();
    base_written = 1'b1;
    traffic_on = 1'b1;
    for (int k = 0; k < 10000; k++) tick();
    check("noimg_count", 32'(inj_count), 32'd0);
    check("noimg_busy", 32'(restore_busy), 32'd0);

    // Reset mid-restore, then a fresh image.
    game_idle();
    do_reset();
    random_image();
    load_image();
    pulse_load_done();
    armed = 1'b1;
    wait_count(40, 200);
    do_reset();
    for (int k = 0; k < 30; k++) tick();
    check("post_reset_count", 32'(inj_count), 32'd0);
    check("post_reset_busy", 32'(restore_busy), 32'd0);
    check("post_reset_done", 32'(restore_done), 32'd0);
    random_image();
    load_image();
    armed = 1'b1;
    pulse_load_done();
    wait_done(400);
    check("reload_count", 32'(inj_count), 32'(N));
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
